vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync generator. Produces hsync/vsync, pixel coordinates, active-video, vblank, line/frame strobes and a frame counter, all registered and mutually aligned. Advances only on a pixel clock-enable, so it runs from a faster system clock. Adds a lookahead coordinate pair so framebuffer and sprite reads with LOOKAHEAD ticks of latency land on the matching pixel.

Parameters:
H_VAREA, 640, visible pixels per line
H_FRONTP, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync width (ticks)
H_BACKP, 48, horizontal back porch (ticks)
V_VAREA, 480, visible lines
V_FRONTP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACKP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
LOOKAHEAD, 0, fetch-coordinate lead in pixel ticks; legal range 0..H_TOTAL-1
CNT_W, 10, coordinate width; H_TOTAL and V_TOTAL must each be <= 2**CNT_W
FRAME_W, 8, frame counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel tick enable; tie to 1 for clk = pixel clock
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
col  out  CNT_W  current horizontal position
row  out  CNT_W  current vertical position
valid  out  1  col < H_VAREA and row < V_VAREA
vblank  out  1  row >= V_VAREA
line_start  out  1  high while col == 0
frame_start  out  1  high while col == 0 and row == 0
frame_cnt  out  FRAME_W  completed frames since reset, mod 2**FRAME_W
fetch_col  out  CNT_W  horizontal position LOOKAHEAD ticks ahead of col
fetch_row  out  CNT_W  vertical position of that lookahead point
fetch_valid  out  1  lookahead point is in the visible area

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n); the polarity and synchronicity are fixed.
- H_TOTAL = sum of the H_* parameters (default 800). V_TOTAL = sum of the V_* parameters (default 525).
- Reset values:
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - col, row, fetch_col, fetch_row, frame_cnt = 0.
  - valid, fetch_valid, vblank, line_start, frame_start = 0.
  - Internal main position = (0,0).
  - Internal lookahead position = (LOOKAHEAD,0).
- Pixel tick = a rising clk edge with pix_ce = 1. With pix_ce = 0, all state and outputs hold.
- On each tick:
  - Every output is loaded from a decode of the current internal position.
  - The position then advances: h+1. When h == H_TOTAL-1, h goes to 0 and v+1. When v == V_TOTAL-1 as well, v goes to 0.
  - Net effect: the first tick after reset release presents (0,0) with valid = 1, line_start = 1, frame_start = 1 and frame_cnt = 0.
  - Output latency is exactly one tick from the internal position. Every output is a flop, with no combinational path from any input.
- Sync decode:
  - hsync is active while H_VAREA+H_FRONTP <= h < H_VAREA+H_FRONTP+H_SYNC; default 656..751.
  - vsync is active while V_VAREA+V_FRONTP <= v < V_VAREA+V_FRONTP+V_SYNC; default 490..491.
  - vsync changes are aligned to the tick where col = 0.
- frame_cnt increments, wrapping, on every tick that presents (0,0) except the first one after reset.
- Lookahead:
  - A second position counter runs with the same advance and wrap rules and is reset to (LOOKAHEAD,0).
  - fetch_* always equal the decode of the main position + LOOKAHEAD ticks, with wrap across line and frame.
  - LOOKAHEAD = 0 gives fetch_* identical to col/row/valid.
- Boundaries:
  - Wrap (H_TOTAL-1, V_TOTAL-1) -> (0,0) takes one tick.
  - Reset asserted mid-frame forces reset values immediately (asynchronously). Timing restarts at (0,0) on the first tick after release.
  - pix_ce high on the reset-release edge counts as a tick only if rst_n was already high before that edge.
- Illegal parameters (LOOKAHEAD >= H_TOTAL, or totals exceeding 2**CNT_W) fail elaboration via a static assertion.

Decomposition:
- Package vga_timing_pkg:
  - Timing-preset constants for 640x480@60 (defaults) and 800x600@60 (40, 128, 88, 800 / 1, 4, 23, 600).
  - A helper function for computing totals.
- Sub-module vga_pos_counter:
  - h/v counter pair with pix_ce, parametrised reset position and wrap at H_TOTAL/V_TOTAL.
  - Instantiated twice, for the main position and the lookahead position.

Test Plan:
- Defaults, pix_ce = 1: release reset, then the first tick gives col = 0, row = 0, valid = 1, frame_start = 1, frame_cnt = 0. line_start recurs every 800 clks, frame_start every 420000 clks, and frame_cnt reads 1 at the second frame_start.
- Defaults: hsync is low for exactly col 656..751, valid = 0 from col 640. vsync is low for rows 490..491 only. vblank = 1 for rows 480..524.
- pix_ce high 1 clk in 4: outputs change only on enabled edges. Line period is 3200 clks. Holding pix_ce = 0 for 100 clks freezes every output.
- LOOKAHEAD = 2:
  - At col = 10, row = 5: fetch (12, 5).
  - At col = 798, row = 5: fetch (0, 6).
  - At (799, 524): fetch (1, 0) with fetch_valid = 1.
- rst_n pulsed low at (300, 200): outputs go to reset values without waiting for a clk edge. The first tick after release gives (0,0), and frame_cnt = 0.
- Small timing (H 8/2/2/2, V 4/1/1/1), HS_POL = 1, VS_POL = 1: hsync is high for col 10..11, vsync is high for row 5. frame_cnt wraps at 2**FRAME_W with FRAME_W = 2 (0 -> 3 -> 0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing presets and helpers for the parametrised VGA timing generator.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int VGA640_H_VAREA  = 640;
  localparam int VGA640_H_FRONTP = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACKP  = 48;
  localparam int VGA640_V_VAREA  = 480;
  localparam int VGA640_V_FRONTP = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACKP  = 33;

  // 800x600 @ 60 Hz (40 MHz pixel clock)
  localparam int SVGA800_H_VAREA  = 800;
  localparam int SVGA800_H_FRONTP = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACKP  = 88;
  localparam int SVGA800_V_VAREA  = 600;
  localparam int SVGA800_V_FRONTP = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACKP  = 23;

  function automatic int calc_total(input int varea, input int frontp,
                                    input int sync, input int backp);
    return varea + frontp + sync + backp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pos_counter.sv
// h/v position counter pair advancing on pix_ce, wrapping at the line and frame totals.
module vga_pos_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CNT_W   = 10,
  parameter int H_INIT  = 0,
  parameter int V_INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= CNT_W'(H_INIT);
      v <= CNT_W'(V_INIT);
    end else if (pix_ce) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
      end else begin
        h <= h + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: registered syncs, coordinates, strobes and a lookahead fetch position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VAREA   = VGA640_H_VAREA,
  parameter int H_FRONTP  = VGA640_H_FRONTP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACKP   = VGA640_H_BACKP,
  parameter int V_VAREA   = VGA640_V_VAREA,
  parameter int V_FRONTP  = VGA640_V_FRONTP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACKP   = VGA640_V_BACKP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOOKAHEAD = 0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic [CNT_W-1:0]   col,
  output logic [CNT_W-1:0]   row,
  output logic               valid,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [CNT_W-1:0]   fetch_col,
  output logic [CNT_W-1:0]   fetch_row,
  output logic               fetch_valid
);

  localparam int H_TOTAL = calc_total(H_VAREA, H_FRONTP, H_SYNC, H_BACKP);
  localparam int V_TOTAL = calc_total(V_VAREA, V_FRONTP, V_SYNC, V_BACKP);

  if (LOOKAHEAD < 0 || LOOKAHEAD >= H_TOTAL ||
      H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_param_check
    $error("vga_timing_gen: illegal LOOKAHEAD or totals exceed 2**CNT_W");
  end

  // One extra bit so a sync end equal to the total still compares correctly.
  localparam logic [CNT_W:0] H_VIS  = (CNT_W+1)'(H_VAREA);
  localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_VAREA + H_FRONTP);
  localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_VAREA + H_FRONTP + H_SYNC);
  localparam logic [CNT_W:0] V_VIS  = (CNT_W+1)'(V_VAREA);
  localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_VAREA + V_FRONTP);
  localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_VAREA + V_FRONTP + V_SYNC);

  logic [CNT_W-1:0] h, v, la_h, la_v;
  logic             h_vis, v_vis, la_vis, hs_act, vs_act, at_origin;
  logic             frame_seen;

  vga_pos_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .CNT_W(CNT_W), .H_INIT(0), .V_INIT(0)
  ) u_main_pos (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .h(h), .v(v)
  );

  vga_pos_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .CNT_W(CNT_W), .H_INIT(LOOKAHEAD), .V_INIT(0)
  ) u_fetch_pos (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .h(la_h), .v(la_v)
  );

  assign h_vis     = {1'b0, h} < H_VIS;
  assign v_vis     = {1'b0, v} < V_VIS;
  assign la_vis    = ({1'b0, la_h} < H_VIS) && ({1'b0, la_v} < V_VIS);
  assign hs_act    = ({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END);
  assign vs_act    = ({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END);
  assign at_origin = (h == '0) && (v == '0);

  // Outputs show the position held before the counters advance, giving one tick of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      col         <= '0;
      row         <= '0;
      valid       <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      fetch_col   <= '0;
      fetch_row   <= '0;
      fetch_valid <= 1'b0;
      frame_seen  <= 1'b0;
    end else if (pix_ce) begin
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      col         <= h;
      row         <= v;
      valid       <= h_vis && v_vis;
      vblank      <= !v_vis;
      line_start  <= (h == '0);
      frame_start <= at_origin;
      fetch_col   <= la_h;
      fetch_row   <= la_v;
      fetch_valid <= la_vis;
      // The first origin after reset starts frame 0 rather than completing one.
      if (at_origin) begin
        if (frame_seen) frame_cnt <= frame_cnt + FRAME_W'(1);
        frame_seen <= 1'b1;
      end
    end
  end

endmodule
